// File: rtl/bias_acc_relu_stage.sv
// Bias inject + N_PASS saturating accumulation + output register stage.
// Optional output ReLU when BIAS_ACC_RELU_EN is defined.
module bias_acc_relu_stage #(
    parameter int N_adder_tree = 16,
    parameter int DW           = 18,
    parameter int N_PASS       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_adder_tree*DW-1:0]     bias_in,
    input  logic [N_adder_tree*DW-1:0]     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N_adder_tree*DW-1:0]     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(N_PASS+1)-1:0]    pass_cnt
);

    localparam int W  = N_adder_tree * DW;
    localparam int CW = $clog2(N_PASS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_PASS - 1);

    function automatic logic [DW-1:0] sat(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1])
            sat = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat = s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] act(input logic [DW-1:0] x);
`ifdef BIAS_ACC_RELU_EN
        act = x[DW-1] ? '0 : x;
`else
        act = x;
`endif
    endfunction

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  out_q, out_d;
    logic          ov_q, ov_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  base, sum, res;
    logic          last, fire;

    assign last     = (cnt_q == LAST);
    assign in_ready = !(last && ov_q && !out_ready);
    assign fire     = in_valid && in_ready;
    // First beat of a vector starts from the bias instead of acc.
    assign base     = (cnt_q == '0) ? bias_in : acc_q;

    always_comb begin
        sum = '0;
        res = '0;
        for (int i = 0; i < N_adder_tree; i++) begin
            sum[DW*i +: DW] = sat(base[DW*i +: DW], in_data[DW*i +: DW]);
            res[DW*i +: DW] = act(sum[DW*i +: DW]);
        end
    end

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        cnt_d = cnt_q;
        ov_d  = ov_q && !out_ready;
        if (fire) begin
            if (last) begin
                out_d = res;
                ov_d  = 1'b1;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
            ov_q  <= ov_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = ov_q;
    assign pass_cnt  = cnt_q;

endmodule

// File: tb/tb_bias_acc_relu_stage.sv
// Self-checking bench for bias_acc_relu_stage (N_PASS=4 and N_PASS=1 instances).
// Build with +define+BIAS_ACC_RELU_EN to check the ReLU variant.
module tb_bias_acc_relu_stage;

    localparam int NL = 16;
    localparam int DW = 18;
    localparam int NP = 4;
    localparam int W  = NL * DW;
    localparam int MAXV = 131071;
    localparam int MINV = -131072;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bias_in, in_data, out_data;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   pass_cnt;

    logic [W-1:0] bias1, in1, od1;
    logic         iv1, ir1, ov1, or1;
    logic [0:0]   pc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bias_acc_relu_stage #(.N_adder_tree(NL), .DW(DW), .N_PASS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .bias_in(bias_in), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .pass_cnt(pass_cnt)
    );

    bias_acc_relu_stage #(.N_adder_tree(NL), .DW(DW), .N_PASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bias_in(bias1), .in_data(in1),
        .in_valid(iv1), .in_ready(ir1), .out_data(od1),
        .out_valid(ov1), .out_ready(or1), .pass_cnt(pc1)
    );

    typedef struct {
        string name;
        int    bias;
        int    b[4];
        int    exp_off;
        int    exp_on;
    } vec_t;

    function automatic int clampi(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic int actf(input int v);
`ifdef BIAS_ACC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[DW*i +: DW] = DW'(v);
        return r;
    endfunction

    function automatic int lane(input logic [W-1:0] v, input int i);
        logic signed [DW-1:0] x;
        x = v[DW*i +: DW];
        return int'(x);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] expq[$];
        logic [W-1:0] e;
        int           acc[NL];
        int           bidx, ex, rdy, bse;

        tbl[0] = '{"sat_pos",   131000, '{100, 100, 100, 100}, 131071, 131071};
        tbl[1] = '{"sat_neg",  -131000, '{-100, -100, -100, -100}, -131072, 0};
        tbl[2] = '{"relu",        -200, '{10, 10, 10, 10}, -160, 0};
        tbl[3] = '{"plain",          5, '{1, 2, 3, 4}, 15, 15};
        tbl[4] = '{"no_hidden",      0, '{131071, 131071, -131072, 0}, -1, 0};
        tbl[5] = '{"neg_mid",       50, '{-100, -100, 0, 200}, 50, 50};

        rst_n = 1'b0;
        bias_in = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        bias1 = '0; in1 = '0; iv1 = 1'b0; or1 = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chkv("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        cyc();
        chk("rst_in_ready", in_ready, 1);

        // N_PASS=1 instance
        bias1 = '0;
        bias1[DW-1:0] = DW'(8888);
        in1 = rep(5);
        in1[DW-1:0] = DW'(1000);
        iv1 = 1'b1;
        #1;
        chk("np1_in_ready", ir1, 1);
        cyc();
        iv1 = 1'b0;
        e = rep(5);
        e[DW-1:0] = DW'(9888);
        chk("np1_out_valid", ov1, 1);
        chkv("np1_out_data", od1, e);

        // Table-driven vectors
        for (int t = 0; t < 6; t++) begin
`ifdef BIAS_ACC_RELU_EN
            ex = tbl[t].exp_on;
`else
            ex = tbl[t].exp_off;
`endif
            bias_in = rep(tbl[t].bias);
            out_ready = 1'b1;
            for (int k = 0; k < NP; k++) beat(rep(tbl[t].b[k]));
            chk({tbl[t].name, "_valid"}, out_valid, 1);
            chkv({tbl[t].name, "_data"}, out_data, rep(ex));
        end

        // Backpressure
        cyc();
        bias_in = '0;
        out_ready = 1'b0;
        for (int k = 0; k < NP; k++) beat(rep(1));
        chk("bp_a_valid", out_valid, 1);
        chkv("bp_a_data", out_data, rep(4));
        for (int k = 0; k < NP - 1; k++) begin
            in_valid = 1'b1;
            in_data = rep(2);
            #1;
            chk("bp_b_ready", in_ready, 1);
            cyc();
        end
        #1;
        chk("bp_last_stall", in_ready, 0);
        cyc();
        chk("bp_hold_cnt", pass_cnt, NP - 1);
        chkv("bp_hold_data", out_data, rep(4));
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("bp_b_valid", out_valid, 1);
        chkv("bp_b_data", out_data, rep(8));
        cyc();
        chk("bp_drained", out_valid, 0);

        // Back-to-back throughput
        bias_in = rep(7);
        for (int k = 0; k < 3 * NP; k++) begin
            in_valid = 1'b1;
            in_data = rep(k);
            cyc();
            chk("tp_valid", out_valid, (k % NP == NP - 1) ? 1 : 0);
            if (k % NP == NP - 1)
                chkv("tp_data", out_data, rep(7 + 4 * k - 6));
        end
        in_valid = 1'b0;
        cyc();

        // Reset mid-vector with a pending output
        bias_in = rep(100);
        out_ready = 1'b0;
        for (int k = 0; k < NP; k++) beat(rep(1000));
        beat(rep(1000));
        beat(rep(1000));
        chk("rm_pre_cnt", pass_cnt, 2);
        chk("rm_pre_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_cnt", pass_cnt, 0);
        chk("rm_valid", out_valid, 0);
        chkv("rm_data", out_data, '0);
        #1 rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        for (int k = 0; k < NP; k++) beat(rep(k + 1));
        chk("rm_fresh_valid", out_valid, 1);
        chkv("rm_fresh_data", out_data, rep(110));
        cyc();

        // Randomized against a per-vector arithmetic model
        for (int i = 0; i < NL; i++) bias_in[DW*i +: DW] = DW'($urandom);
        bidx = 0;
        for (int c = 0; c < 2100; c++) begin
            if (c < 2000) begin
                in_valid = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(4) > 1);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            for (int i = 0; i < NL; i++) in_data[DW*i +: DW] = DW'($urandom);
            #1;
            rdy = !(bidx == NP - 1 && expq.size() != 0 && !out_ready);
            chk("rnd_in_ready", in_ready, rdy);
            chk("rnd_out_valid", out_valid, (expq.size() != 0) ? 1 : 0);
            chk("rnd_pass_cnt", pass_cnt, bidx);
            if (expq.size() != 0 && out_ready) begin
                e = expq.pop_front();
                chkv("rnd_out_data", out_data, e);
            end
            if (in_valid && rdy) begin
                for (int i = 0; i < NL; i++) begin
                    bse = (bidx == 0) ? lane(bias_in, i) : acc[i];
                    acc[i] = clampi(bse + lane(in_data, i));
                end
                if (bidx == NP - 1) begin
                    for (int i = 0; i < NL; i++) e[DW*i +: DW] = DW'(actf(acc[i]));
                    expq.push_back(e);
                end
                bidx = (bidx + 1) % NP;
            end
            cyc();
        end
        chk("rnd_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
